// File: rtl/n1_prog_loader.sv
// n1_prog_loader: host-side program loader for the n1 core.
// Receives a framed byte stream (count N, then N big-endian 16-bit words),
// writes the words to core RAM addresses 0..N-1 while holding the core in
// reset, then releases the core to run.
//
// Optional feature macro: N1_LOADER_VERIFY_EN
//   When defined, every written word is read back through mem_rdata and
//   compared; a mismatch ends the load with err_code 11.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_data  host byte stream, s_ready accepts (transfer = valid & ready)
//   load_req        one-cycle pulse, restarts a load from RUN or ERROR
//   mem_addr/mem_wdata/mem_we  core RAM write port (mem_we one-cycle pulse)
//   mem_rdata       core RAM readback (verify build only)
//   cpu_rst_n       core reset, released only in RUN
//   done, err, err_code  status: 01 bad count, 10 timeout, 11 verify mismatch
module n1_prog_loader #(
    parameter int unsigned RAM_WORDS    = 127,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned BYTE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              load_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic [15:0]       mem_rdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned TMO_W = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
`ifdef N1_LOADER_VERIFY_EN
    localparam logic [1:0] ERR_VERIFY = 2'b11;
`endif

    typedef enum logic [2:0] {
        S_HEADER,
        S_HI,
        S_LO,
        S_WRITE,
        S_RUN,
        S_ERROR
`ifdef N1_LOADER_VERIFY_EN
        ,
        S_VER1,
        S_VER2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [15:0]        wdata_d;
    logic [1:0]         err_code_d;
    logic               s_ready_d, we_d, cpu_rst_n_d, done_d, err_d;
    logic               xfer;
    logic               last_word;
    logic               tmo_hit;

    assign xfer      = s_valid & s_ready;
    assign last_word = (mem_addr == last_q);
    assign tmo_hit   = (tmo_q == TMO_W'(BYTE_TIMEOUT - 1));

`ifndef N1_LOADER_VERIFY_EN
    // Readback port exists for pin compatibility only.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Next-state and next-output logic; outputs are registered from state_d.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        err_code_d = err_code;

        case (state_q)
            S_HEADER: begin
                tmo_d = '0;
                if (xfer) begin
                    if (s_data == 8'd0 || 32'(s_data) > RAM_WORDS) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_COUNT;
                    end else begin
                        last_d  = ADDR_W'(s_data - 8'd1);
                        addr_d  = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = s_data;
                    tmo_d   = '0;
                    state_d = S_LO;
                end else if (tmo_hit) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_LO: begin
                if (xfer) begin
                    wdata_d = {hi_q, s_data};
                    tmo_d   = '0;
                    state_d = S_WRITE;
                end else if (tmo_hit) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITE: begin
                tmo_d = '0;
`ifdef N1_LOADER_VERIFY_EN
                state_d = S_VER1;
`else
                if (last_word) begin
                    state_d = S_RUN;
                end else begin
                    addr_d  = mem_addr + ADDR_W'(1);
                    state_d = S_HI;
                end
`endif
            end
`ifdef N1_LOADER_VERIFY_EN
            // First cycle lets the core register its readback of mem_addr.
            S_VER1: state_d = S_VER2;
            S_VER2: begin
                if (mem_rdata != mem_wdata) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_VERIFY;
                end else if (last_word) begin
                    state_d = S_RUN;
                end else begin
                    addr_d  = mem_addr + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
`endif
            S_RUN: begin
                if (load_req) state_d = S_HEADER;
            end
            S_ERROR: begin
                if (load_req) begin
                    state_d    = S_HEADER;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = S_HEADER;
        endcase

        s_ready_d   = (state_d == S_HEADER) || (state_d == S_HI) || (state_d == S_LO);
        we_d        = (state_d == S_WRITE);
        cpu_rst_n_d = (state_d == S_RUN);
        done_d      = (state_d == S_RUN);
        err_d       = (state_d == S_ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HEADER;
            hi_q      <= '0;
            last_q    <= '0;
            tmo_q     <= '0;
            s_ready   <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            s_ready   <= s_ready_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
            cpu_rst_n <= cpu_rst_n_d;
            done      <= done_d;
            err       <= err_d;
            err_code  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_n1_prog_loader.sv
// Testbench for n1_prog_loader: directed and randomized frames checked
// against a frame-level model (expected writes derived from the byte list).
module tb_n1_prog_loader;

    localparam int unsigned RAM_WORDS    = 127;
    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned BYTE_TIMEOUT = 1024;
`ifdef N1_LOADER_VERIFY_EN
    localparam int DONE_LAT = 3;
`else
    localparam int DONE_LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              load_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic [15:0]       mem_rdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    n1_prog_loader #(
        .RAM_WORDS(RAM_WORDS),
        .ADDR_W(ADDR_W),
        .BYTE_TIMEOUT(BYTE_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .load_req(load_req),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .cpu_rst_n(cpu_rst_n),
        .done(done),
        .err(err),
        .err_code(err_code)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Core RAM model with one-edge registered readback; can corrupt 0x1005.
    logic [15:0] ram [0:127];
    bit corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (corrupt && ram[mem_addr] == 16'h1005) ? 16'h1004 : ram[mem_addr];
    end

    // Monitor: log every write pulse and the rise cycles of done / err.
    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t  wq[$];
    int   done_cyc = -1;
    int   err_cyc  = -1;
    logic done_p   = 1'b0;
    logic err_p    = 1'b0;
    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
        if (done === 1'b1 && done_p !== 1'b1) done_cyc = cyc;
        if (err === 1'b1 && err_p !== 1'b1) err_cyc = cyc;
        done_p = done;
        err_p  = err;
    end

    logic [7:0] fr[$];
    int         lo_q[$];
    int         wbase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte from a negedge; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, output int xc);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        xc      = cyc;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    // Send fr with random idle gaps, optionally pulsing load_req while idle.
    task automatic send_frame(input int gap_max, input bit pulse);
        int xc;
        for (int i = 0; i < fr.size(); i++) begin
            int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int j = 0; j < g; j++) begin
                load_req = pulse && ($urandom_range(0, 1) == 1);
                @(negedge clk);
                load_req = 1'b0;
            end
            send_byte(fr[i], xc);
            if (i > 0 && (i % 2) == 0) lo_q.push_back(xc);
        end
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_bound", 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    // Expected result of a good frame: word i = {fr[2i+1], fr[2i+2]} at addr i.
    task automatic check_frame(input string tag);
        int n    = int'(fr[0]);
        int got  = wq.size() - wbase;
        chk({tag, "_nwr"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            chk({tag, "_addr"}, 32'(wq[wbase+i].addr), 32'(i));
            chk({tag, "_data"}, 32'(wq[wbase+i].data), 32'({fr[1+2*i], fr[2+2*i]}));
            if (i < lo_q.size()) chk({tag, "_wlat"}, 32'(wq[wbase+i].cyc), 32'(lo_q[i]));
        end
        if (got > 0) chk({tag, "_dlat"}, 32'(done_cyc - wq[wq.size()-1].cyc), 32'(DONE_LAT));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    endtask

    task automatic begin_frame();
        wbase = wq.size();
        lo_q.delete();
        fr.delete();
    endtask

    task automatic restart(input string tag);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
    endtask

    task automatic rand_frame(input int n);
        fr.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom));
    endtask

    initial begin
        int xc;
        int hi_cyc;
        logic [7:0] bad_hdr[3];
        bad_hdr[0] = 8'h00;
        bad_hdr[1] = 8'h80;
        bad_hdr[2] = 8'hFF;

        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; load_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Directed back-to-back frame.
        begin_frame();
        fr = '{8'h02, 8'h10, 8'h05, 8'h20, 8'h07};
        send_frame(0, 1'b0);
        wait_end(20);
        check_frame("t1");

        // Randomized frames: N=1, N=RAM_WORDS, then small random counts.
        for (int k = 0; k < 6; k++) begin
            int n = (k == 0) ? 1 : (k == 1) ? int'(RAM_WORDS) : int'($urandom_range(2, 10));
            restart("rs_run");
            begin_frame();
            rand_frame(n);
            send_frame(3, 1'b1);
            wait_end(2000);
            check_frame("rnd");
        end

        // Bad counts.
        for (int k = 0; k < 3; k++) begin
            restart("rs_bad");
            begin_frame();
            send_byte(bad_hdr[k], xc);
            repeat (3) @(negedge clk);
            chk("bad_err", 32'(err), 32'd1);
            chk("bad_code", 32'(err_code), 32'd1);
            chk("bad_cpurst", 32'(cpu_rst_n), 32'd0);
            chk("bad_nowr", 32'(wq.size() - wbase), 32'd0);
        end

        // HEADER waits forever; a stall in a frame times out.
        restart("rs_tmo");
        repeat (BYTE_TIMEOUT + 50) @(negedge clk);
        chk("hdr_notmo", 32'(err), 32'd0);
        chk("hdr_ready", 32'(s_ready), 32'd1);
        begin_frame();
        send_byte(8'h01, xc);
        send_byte(8'h70, hi_cyc);
        wait_end(BYTE_TIMEOUT + 20);
        chk("tmo_code", 32'(err_code), 32'd2);
        chk("tmo_lat", 32'(err_cyc - hi_cyc), 32'(BYTE_TIMEOUT));
        chk("tmo_cpurst", 32'(cpu_rst_n), 32'd0);
        chk("tmo_nowr", 32'(wq.size() - wbase), 32'd0);

        // Longest tolerated stall: BYTE_TIMEOUT-1 idle cycles then the lo byte.
        restart("rs_slow");
        begin_frame();
        fr = '{8'h01, 8'hAB, 8'hCD};
        send_byte(fr[0], xc);
        send_byte(fr[1], xc);
        repeat (BYTE_TIMEOUT - 1) @(negedge clk);
        send_byte(fr[2], xc);
        lo_q.push_back(xc);
        wait_end(20);
        check_frame("slow");

        // Reset while waiting for a lo byte, then a clean frame.
        restart("rs_rst");
        begin_frame();
        send_byte(8'h02, xc);
        send_byte(8'h11, xc);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        chk("midrst_nowr", 32'(wq.size() - wbase), 32'd0);
        begin_frame();
        rand_frame(int'($urandom_range(1, 6)));
        send_frame(2, 1'b1);
        wait_end(200);
        check_frame("postrst");

`ifdef N1_LOADER_VERIFY_EN
        // Core returns 0x1004 for a stored 0x1005: verify must flag it.
        restart("rs_ver");
        corrupt = 1'b1;
        begin_frame();
        fr = '{8'h02, 8'h10, 8'h05, 8'h20, 8'h07};
        send_frame(0, 1'b0);
        wait_end(50);
        chk("ver_err", 32'(err), 32'd1);
        chk("ver_code", 32'(err_code), 32'd3);
        chk("ver_done", 32'(done), 32'd0);
        chk("ver_nwr", 32'(wq.size() - wbase), 32'd1);
        corrupt = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
